// File: rtl/arbitro_memoria_relacoes.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_relacoes
//
// Round-robin arbiter for the single read port of the external relations
// memory. Requesters (valid-neighbour locators plus the path builder) raise a
// level request with an address; one read is issued per cycle. A tag pipeline
// follows every issued read through the memory latency so the returned word
// is delivered to the requester that asked for it.
//
// Handshake: req_in[i] is a level request. The requester keeps req_in[i] and
// its address slice stable until it sees gnt_out[i] high for one cycle; in
// that cycle it either drops the request or keeps it high to ask again. A
// requester whose grant is currently visible is not eligible, so a lone
// continuous requester is served every second cycle. The response is a
// one-cycle rd_valid_out[i] pulse with rd_data_out, in issue order.
//
// Ports
//   clk               clock
//   rst_n             asynchronous active-low reset
//   limpar_in         synchronous flush: drops in-flight reads, resets priority
//   req_in            per-requester read request (level)
//   req_addr_in       per-requester address, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt_out           one-hot grant pulse (registered)
//   mem_rd_enable_out read enable to memory (registered)
//   mem_rd_addr_out   read address to memory (registered)
//   mem_rd_data_in    memory data, valid LATENCIA cycles after the enable
//   rd_valid_out      one-hot response-valid pulse (registered)
//   rd_data_out       response data shared by all requesters, holds when idle
//   ocupado_out       high while any read is in flight
// -----------------------------------------------------------------------------
module arbitro_memoria_relacoes #(
  parameter int NUM_REQ             = 4,
  parameter int ADDR_WIDTH          = 10,
  parameter int RELACOES_DATA_WIDTH = 112,
  parameter int LATENCIA            = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            limpar_in,
  input  logic [NUM_REQ-1:0]              req_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]              gnt_out,
  output logic                            mem_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr_out,
  input  logic [RELACOES_DATA_WIDTH-1:0]  mem_rd_data_in,
  output logic [NUM_REQ-1:0]              rd_valid_out,
  output logic [RELACOES_DATA_WIDTH-1:0]  rd_data_out,
  output logic                            ocupado_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

  // Priority pointer: index of the last requester granted. The search for
  // the next winner starts one position after it.
  logic [PW-1:0] ptr;

  logic [NUM_REQ-1:0]    elig;
  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Tag pipeline: stage i holds {valid, one-hot id} of the read issued
  // i+1 cycles before the enable that is currently visible.
  logic [LATENCIA-1:0] pipe_valid;
  logic [NUM_REQ-1:0]  pipe_id [LATENCIA];

  // A requester whose grant is visible this cycle is masked so a held
  // request is not served twice back-to-back.
  assign elig = req_in & ~gnt_out;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_onehot[i] = win_found;
        win_addr      = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr               <= PTR_RESET;
      gnt_out           <= '0;
      mem_rd_enable_out <= 1'b0;
      mem_rd_addr_out   <= '0;
      rd_valid_out      <= '0;
      rd_data_out       <= '0;
      pipe_valid        <= '0;
      for (int i = 0; i < LATENCIA; i++) begin
        pipe_id[i] <= '0;
      end
    end else if (limpar_in) begin
      // Flush wins over everything: in-flight reads are forgotten and
      // requests presented in this cycle are ignored.
      ptr               <= PTR_RESET;
      gnt_out           <= '0;
      mem_rd_enable_out <= 1'b0;
      rd_valid_out      <= '0;
      pipe_valid        <= '0;
      for (int i = 0; i < LATENCIA; i++) begin
        pipe_id[i] <= '0;
      end
    end else begin
      // Issue stage
      gnt_out           <= win_onehot;
      mem_rd_enable_out <= win_found;
      if (win_found) begin
        mem_rd_addr_out <= win_addr;
        ptr             <= win_idx;
      end

      // Tag pipeline tracks the memory latency
      pipe_valid[0] <= mem_rd_enable_out;
      pipe_id[0]    <= gnt_out;
      for (int i = 1; i < LATENCIA; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end

      // Response stage: data is sampled in the cycle the last stage is valid
      if (pipe_valid[LATENCIA-1]) begin
        rd_valid_out <= pipe_id[LATENCIA-1];
        rd_data_out  <= mem_rd_data_in;
      end else begin
        rd_valid_out <= '0;
      end
    end
  end

  assign ocupado_out = (|pipe_valid) | mem_rd_enable_out;

endmodule
